// File: rtl/mostra_sequencia.sv
// Sequence display controller: walks a ROM from address 0 up to a latched limit,
// lighting each element for T_ACESO cycles followed by T_APAGADO dark cycles.
module mostra_sequencia #(
    parameter int unsigned T_ACESO   = 1000,
    parameter int unsigned T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StOcioso  = 4'd0,
        StPrepara = 4'd1,
        StAcende  = 4'd2,
        StApaga   = 4'd3,
        StFim     = 4'd4
    } state_e;

    localparam logic [11:0] AcesoLast   = 12'(T_ACESO - 1);
    localparam logic [11:0] ApagadoLast = 12'(T_APAGADO - 1);

    state_e      state_q, state_d;
    logic [11:0] timer_q, timer_d;
    logic [3:0]  end_q, end_d;
    logic [3:0]  lim_q, lim_d;
    logic [3:0]  leds_q, leds_d;
    logic        pronto_q, pronto_d;

    // State and datapath registers, all cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StOcioso;
            timer_q  <= 12'd0;
            end_q    <= 4'd0;
            lim_q    <= 4'd0;
            leds_q   <= 4'd0;
            pronto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            end_q    <= end_d;
            lim_q    <= lim_d;
            leds_q   <= leds_d;
            pronto_q <= pronto_d;
        end
    end

    // Next-state logic; pronto is set on the transition into StFim so it is high
    // exactly during the single StFim cycle.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        end_d    = end_q;
        lim_d    = lim_q;
        leds_d   = leds_q;
        pronto_d = 1'b0;
        case (state_q)
            StOcioso: begin
                leds_d = 4'd0;
                if (iniciar) begin
                    lim_d   = limite;
                    end_d   = 4'd0;
                    timer_d = 12'd0;
                    state_d = StPrepara;
                end
            end
            StPrepara: begin
                // ROM output for end_q has settled during this cycle.
                leds_d  = dado;
                timer_d = 12'd0;
                state_d = StAcende;
            end
            StAcende: begin
                if (timer_q == AcesoLast) begin
                    timer_d = 12'd0;
                    leds_d  = 4'd0;
                    state_d = StApaga;
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            StApaga: begin
                if (timer_q == ApagadoLast) begin
                    timer_d = 12'd0;
                    if (end_q == lim_q) begin
                        state_d  = StFim;
                        pronto_d = 1'b1;
                    end else begin
                        end_d   = end_q + 4'd1;
                        state_d = StPrepara;
                    end
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            StFim: begin
                state_d = StOcioso;
            end
            default: begin
                state_d = StOcioso;
                timer_d = 12'd0;
                leds_d  = 4'd0;
            end
        endcase
    end

    // Outputs come straight from registers; ocupado decodes the state register only.
    always_comb begin
        endereco  = end_q;
        leds      = leds_q;
        pronto    = pronto_q;
        db_estado = state_q;
        ocupado   = (state_q == StPrepara) || (state_q == StAcende) || (state_q == StApaga);
    end

endmodule

// File: tb/tb_mostra_sequencia.sv
// Scoreboard bench for mostra_sequencia with T_ACESO=4, T_APAGADO=2 (7 cycles/element).
module tb_mostra_sequencia;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic       ocupado;
        logic       pronto;
        logic [3:0] estado;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];
    obs_t       sb [$];
    obs_t       got;
    obs_t       exp_v;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    // ROM output is a function of the registered address, stable within PREPARA.
    assign dado = rom[endereco];
    assign got  = '{leds: leds, endereco: endereco, ocupado: ocupado, pronto: pronto,
                    estado: db_estado};

    mostra_sequencia #(
        .T_ACESO   (4),
        .T_APAGADO (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    function automatic string show(input obs_t x);
        return $sformatf("leds=%h endereco=%h ocupado=%b pronto=%b estado=%h",
                         x.leds, x.endereco, x.ocupado, x.pronto, x.estado);
    endfunction

    function automatic obs_t mk(input int l, input int e, input bit o, input bit p, input int s);
        obs_t r;
        r.leds     = 4'(l);
        r.endereco = 4'(e);
        r.ocupado  = o;
        r.pronto   = p;
        r.estado   = 4'(s);
        return r;
    endfunction

    // Expected per-cycle observations for a full run, cycle 1 onward, plus one idle cycle.
    task automatic push_run(input int lim);
        for (int k = 0; k <= lim; k++) begin
            sb.push_back(mk(0, k, 1, 0, 1));
            for (int i = 0; i < 4; i++) sb.push_back(mk(int'(rom[k]), k, 1, 0, 2));
            for (int i = 0; i < 2; i++) sb.push_back(mk(0, k, 1, 0, 3));
        end
        sb.push_back(mk(0, lim, 0, 1, 4));
        sb.push_back(mk(0, lim, 0, 0, 0));
    endtask

    // Present iniciar for the edge that counts as cycle 0.
    task automatic start(input logic [3:0] lim);
        limite  = lim;
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        limite  = 4'd9;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #2;
        n_vec++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_async: got %s, want all zero", show(got));
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_vec++;
            if (got !== mk(0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %s, want all zero", c, show(got));
            end
        end
    endtask

    task automatic test_basic;
        int cyc;
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4;
        push_run(2);
        start(4'd2);
        cyc = 1;
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL basic cycle %0d: got %s, want %s", cyc, show(got), show(exp_v));
            end
            cyc++;
        end
    endtask

    task automatic test_limite0;
        int cyc;
        push_run(0);
        start(4'd0);
        cyc = 1;
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL limite0 cycle %0d: got %s, want %s", cyc, show(got), show(exp_v));
            end
            cyc++;
        end
    endtask

    task automatic test_ignore_restart;
        int cyc;
        push_run(2);
        start(4'd2);
        cyc = 1;
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL ignore cycle %0d: got %s, want %s", cyc, show(got), show(exp_v));
            end
            // Element 1 is lit in cycles 9..12.
            if (cyc == 9) begin
                iniciar = 1'b1;
                limite  = 4'd0;
            end else if (cyc == 10) begin
                iniciar = 1'b0;
            end
            cyc++;
        end
    endtask

    task automatic test_long;
        int cyc;
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        push_run(15);
        start(4'd15);
        cyc = 1;
        while (sb.size() > 0) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL long cycle %0d: got %s, want %s", cyc, show(got), show(exp_v));
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4;
        push_run(2);
        start(4'd2);
        // Element 1 is dark in cycles 13..14.
        for (cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL midrun cycle %0d: got %s, want %s", cyc, show(got), show(exp_v));
            end
        end
        sb.delete();
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL midrun_reset_async: got %s, want all zero", show(got));
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            n_vec++;
            if (got !== mk(0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL post_reset_idle cycle %0d: got %s, want all zero", c, show(got));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        test_reset;
        test_basic;
        test_limite0;
        test_ignore_restart;
        test_long;
        test_basic;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mostra_sequencia.md
MOSTRA_SEQUENCIA -- requirements
Module: mostra_sequencia

Interface
REQ-001 Parameter T_ACESO, default 1000: clock cycles each element is lit; legal range 1..4095.
REQ-002 Parameter T_APAGADO, default 500: clock cycles of dark gap after each element; legal range 1..4095.
REQ-003 Port clock  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port iniciar  input  1  start request, sampled on rising edge only in OCIOSO.
REQ-006 Port limite  input  4  index of last element to display; latched on start.
REQ-007 Port dado  input  4  sync_rom_16x4 data_out; valid one cycle after endereco changes.
REQ-008 Port endereco  output  4  ROM address of current element.
REQ-009 Port leds  output  4  one-hot/raw pattern shown to player; 0 when dark.
REQ-010 Port ocupado  output  1  high in every state except OCIOSO and FIM.
REQ-011 Port pronto  output  1  one-cycle pulse: sequence fully shown.
REQ-012 Port db_estado  output  4  current FSM state code.

Function
REQ-013 FSM states and codes SHALL be: OCIOSO=0, PREPARA=1, ACENDE=2, APAGA=3, FIM=4; other codes unused, recover to OCIOSO.
REQ-014 OCIOSO with iniciar=1 SHALL latch limite into an internal register, set endereco=0, clear timer, go PREPARA.
REQ-015 PREPARA SHALL last exactly 1 cycle (ROM latency), leds=0, then go ACENDE loading leds register with dado.
REQ-016 ACENDE SHALL hold leds=captured dado for exactly T_ACESO cycles, timer counting 0..T_ACESO-1, then go APAGA with timer cleared.
REQ-017 APAGA SHALL hold leds=0 for exactly T_APAGADO cycles; at its last cycle, if endereco==latched limite go FIM, else endereco+1 and go PREPARA.
REQ-018 FIM SHALL last 1 cycle with pronto=1, ocupado=0, then go OCIOSO; endereco keeps last value until next start.
REQ-019 Per element cost SHALL be 1+T_ACESO+T_APAGADO cycles; pronto SHALL assert in cycle (limite+1)*(1+T_ACESO+T_APAGADO)+1 after the edge sampling iniciar.
REQ-020 iniciar while not OCIOSO SHALL be ignored; limite changes after start SHALL be ignored.
REQ-021 endereco SHALL never wrap: with limite=15 it stops at 15 and FIM follows.
REQ-022 dado=0 SHALL be displayed as leds=0 for the full T_ACESO window (no skip, timing unchanged).
REQ-023 Timer width SHALL be 12 bits; comparisons against T_ACESO-1 / T_APAGADO-1 only.
REQ-024 leds, endereco, pronto SHALL be registered outputs (no combinational path from dado or iniciar).

Reset
REQ-025 reset=1 SHALL immediately (asynchronously) force state OCIOSO, endereco=0, leds=0, ocupado=0, pronto=0, db_estado=0, timer=0, latched limite=0.
REQ-026 Reset mid-sequence SHALL abort it without pronto; after release block waits in OCIOSO for a new iniciar.

Verification (bench overrides T_ACESO=4, T_APAGADO=2; 7 cycles/element)
REQ-027 Power-up reset pulse -> all outputs 0, db_estado=0 before any clock edge.
REQ-028 ROM[0..2]=1,2,4; limite=2; iniciar 1 cycle -> leds 0(1),1(4),0(2),0(1),2(4),0(2),0(1),4(4),0(2); pronto=1 only in cycle 22; ocupado high cycles 1..21.
REQ-029 limite=0 -> single element ROM[0] shown 4 cycles, pronto in cycle 8, endereco stays 0.
REQ-030 During ACENDE of element 1, pulse iniciar and set limite=0 -> no restart; all 3 elements shown; pronto still cycle 22.
REQ-031 reset asserted mid-APAGA of element 1 (no clock edge) -> leds=0, endereco=0, ocupado=0 at once; no pronto; after release stays OCIOSO until iniciar.
REQ-032 limite=15, ROM=0..15 -> endereco steps 0..15 without wrap; pronto in cycle 113; ocupado low afterwards.
